// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor 0 (Status, Cause, EPC, PRId) with per-line level/edge device interrupts.
// Defining CP0_TIMER_EN adds the Count/Compare timer on the top IP/IM bit.
module cp0_ext #(
   parameter int unsigned        DEV_CNT   = 6,
   parameter logic [DEV_CNT-1:0] EDGE_MASK = '0,
   parameter logic [31:0]        PRID      = 32'h4D495053
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [29:0]        PC,
   input  logic [31:0]        Din,
   input  logic [4:0]         Sel,
   input  logic               Wen,
   input  logic [DEV_CNT:1]   HWInt,
   input  logic               ExcReq,
   input  logic [4:0]         ExcCode,
   input  logic               EXLSet,
   input  logic               EXLClr,
   output logic               IntReq,
   output logic [29:0]        EPC,
   output logic [31:0]        DOut
);

   localparam int unsigned IPL = 10;
   localparam int unsigned IPH = 10 + DEV_CNT;

   logic [DEV_CNT:0] im;
   logic             ie;
   logic             exl;
   logic [4:0]       exc_code;
   logic [29:0]      epc_q;
   logic [DEV_CNT:1] ip_dev;
   logic [DEV_CNT:1] ip_dev_next;
   logic [DEV_CNT:1] hw_prev;
   logic             ip_timer;
   logic [DEV_CNT:0] ip_all;
   logic [31:0]      count_rd;
   logic [31:0]      compare_rd;
   logic [31:0]      sr_val;
   logic [31:0]      cause_val;
   logic             sr_wr;
   logic             cause_wr;
   logic             epc_wr;

   assign sr_wr    = Wen && (Sel == 5'd12);
   assign cause_wr = Wen && (Sel == 5'd13);
   assign epc_wr   = Wen && (Sel == 5'd14);

   // Edge lines latch a rising edge and are W1C through Cause; a same-cycle edge beats the clear.
   for (genvar g = 1; g <= DEV_CNT; g++) begin : g_line
      if (EDGE_MASK[g-1]) begin : g_edge
         assign ip_dev_next[g] = (HWInt[g] & ~hw_prev[g]) |
                                 (ip_dev[g] & ~(cause_wr & Din[IPL+g-1]));
      end else begin : g_level
         assign ip_dev_next[g] = HWInt[g];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         ie       <= 1'b0;
         exl      <= 1'b0;
         exc_code <= '0;
         epc_q    <= '0;
         ip_dev   <= '0;
         hw_prev  <= '0;
      end else begin
         ip_dev  <= ip_dev_next;
         hw_prev <= HWInt;
         if (sr_wr) begin
            im <= Din[IPH:IPL];
            ie <= Din[0];
         end
         // Exception entry outranks eret, SR.EXL writes and EPC writes.
         if (EXLSet) begin
            exl      <= 1'b1;
            epc_q    <= PC;
            exc_code <= ExcReq ? ExcCode : 5'd0;
         end else begin
            if (EXLClr)
               exl <= 1'b0;
            else if (sr_wr)
               exl <= Din[1];
            if (epc_wr)
               epc_q <= Din[31:2];
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic [31:0] count_next;

   assign count_next = (Wen && (Sel == 5'd9)) ? Din : count + 32'd1;

   // Match is taken on the value Count is about to hold, so IP rises with Count==Compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         compare  <= '0;
         ip_timer <= 1'b0;
      end else begin
         count <= count_next;
         if (Wen && (Sel == 5'd11)) begin
            compare  <= Din;
            ip_timer <= 1'b0;
         end else if ((count_next == compare) && (compare != '0)) begin
            ip_timer <= 1'b1;
         end
      end
   end

   assign count_rd   = count;
   assign compare_rd = compare;
`else
   assign ip_timer   = 1'b0;
   assign count_rd   = '0;
   assign compare_rd = '0;
`endif

   assign ip_all = {ip_timer, ip_dev};
   assign IntReq = ExcReq | ((|(ip_all & im)) & ie & ~exl);
   assign EPC    = epc_q;

   always_comb begin
      sr_val            = '0;
      sr_val[IPH:IPL]   = im;
      sr_val[1]         = exl;
      sr_val[0]         = ie;
      cause_val          = '0;
      cause_val[IPH:IPL] = ip_all;
      cause_val[6:2]     = exc_code;
      case (Sel)
         5'd9:    DOut = count_rd;
         5'd11:   DOut = compare_rd;
         5'd12:   DOut = sr_val;
         5'd13:   DOut = cause_val;
         5'd14:   DOut = {epc_q, 2'b00};
         5'd15:   DOut = PRID;
         default: DOut = '0;
      endcase
   end

endmodule
